// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID codes, PID classification helpers,
// the RX classifier state encoding and the output beat format.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_ABORT,
        ST_DROP
    } rx_state_e;

    // dst = 1 steers the beat to the link-layer data path, 0 to the CRC5 path.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       cancle;
        logic       dst;
        logic [7:0] data;
    } rx_beat_t;

    // Upper nibble must be the one's complement of the lower nibble.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

    function automatic logic pid_is_data(input logic [7:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/rx_out_slot.sv
// Single-entry output register shared by the token and data paths; the
// ready of whichever path the held beat targets decides when it drains.
module rx_out_slot
    import usb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load_i,
    input  rx_beat_t beat_i,
    input  logic     ro_ready_i,
    input  logic     lr_ready_i,
    output logic     free_o,
    output logic     valid_o,
    output rx_beat_t beat_o
);

    logic     valid_q, valid_d;
    rx_beat_t beat_q,  beat_d;

    assign free_o  = ~valid_q | (beat_q.dst ? lr_ready_i : ro_ready_i);
    assign valid_o = valid_q;
    assign beat_o  = beat_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        valid_d = valid_q & ~free_o;
        beat_d  = beat_q;
        if (load_i) begin
            valid_d = 1'b1;
            beat_d  = beat_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too because the data/framing outputs must read 0 after reset.
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/control_r.sv
// RX packet classifier: routes PHY bytes to the token (CRC5) or data path by
// PID, drops bad-PID packets and closes over-length/interrupted packets.
module control_r
    import usb_pkg::*;
#(
    parameter int MAX_TOKEN_LEN = 3,
    parameter int MAX_DATA_LEN  = 1027
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pl_sop,
    input  logic       rx_pl_eop,
    input  logic       rx_pl_valid,
    output logic       rx_pl_ready,
    input  logic [7:0] rx_pl_data,
    output logic       rx_ro_sop,
    output logic       rx_ro_eop,
    output logic       rx_ro_valid,
    input  logic       rx_ro_ready,
    output logic [7:0] rx_ro_data,
    output logic       rx_ro_cancle,
    output logic       rx_lr_sop,
    output logic       rx_lr_eop,
    output logic       rx_lr_valid,
    input  logic       rx_lr_ready,
    output logic [7:0] rx_lr_data,
    output logic       rx_lr_cancle,
    output logic       rx_data_on,
    output logic       rx_pid_err
);

    localparam int CNT_W = $clog2(MAX_DATA_LEN + 2);
    localparam logic [CNT_W-1:0] TOKEN_LIM = CNT_W'(MAX_TOKEN_LEN);
    localparam logic [CNT_W-1:0] DATA_LIM  = CNT_W'(MAX_DATA_LEN);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dst_q, dst_d;
    logic             pid_err_q, pid_err_d;

    logic             slot_free, slot_valid, load;
    rx_beat_t         load_beat, out_beat;
    logic [CNT_W-1:0] limit;
    logic             over_len, sop_here;

    rx_out_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .beat_i     (load_beat),
        .ro_ready_i (rx_ro_ready),
        .lr_ready_i (rx_lr_ready),
        .free_o     (slot_free),
        .valid_o    (slot_valid),
        .beat_o     (out_beat)
    );

    assign limit    = (state_q == ST_DATA) ? DATA_LIM : TOKEN_LIM;
    assign over_len = (cnt_q == limit);
    // A sop seen while dropping restarts classification in the same cycle.
    assign sop_here = (state_q == ST_IDLE) | ((state_q == ST_DROP) & rx_pl_sop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        pid_err_d   = 1'b0;
        rx_pl_ready = 1'b0;
        load        = 1'b0;
        load_beat   = '0;

        if (sop_here) begin
            cnt_d = '0;
            if (!rx_pl_sop || !pid_ok(rx_pl_data)) begin
                rx_pl_ready = 1'b1;
                if (rx_pl_valid && rx_pl_sop) begin
                    pid_err_d = 1'b1;
                    state_d   = rx_pl_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                rx_pl_ready = slot_free;
                if (rx_pl_valid && slot_free) begin
                    load           = 1'b1;
                    load_beat.sop  = 1'b1;
                    load_beat.eop  = rx_pl_eop;
                    load_beat.dst  = pid_is_data(rx_pl_data);
                    load_beat.data = rx_pl_data;
                    dst_d          = pid_is_data(rx_pl_data);
                    cnt_d          = CNT_W'(1);
                    if (rx_pl_eop)
                        state_d = ST_IDLE;
                    else
                        state_d = pid_is_data(rx_pl_data) ? ST_DATA : ST_TOKEN;
                end
            end
        end else begin
            case (state_q)
                ST_TOKEN, ST_DATA: begin
                    if (rx_pl_valid && rx_pl_sop) begin
                        state_d = ST_ABORT;
                    end else begin
                        rx_pl_ready = slot_free;
                        if (rx_pl_valid && slot_free) begin
                            load             = 1'b1;
                            load_beat.eop    = rx_pl_eop | over_len;
                            load_beat.cancle = over_len;
                            load_beat.dst    = dst_q;
                            load_beat.data   = rx_pl_data;
                            if (cnt_q != '1)
                                cnt_d = cnt_q + CNT_W'(1);
                            if (rx_pl_eop) begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end else if (over_len) begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                end
                ST_ABORT: begin
                    if (slot_free) begin
                        load             = 1'b1;
                        load_beat.eop    = 1'b1;
                        load_beat.cancle = 1'b1;
                        load_beat.dst    = dst_q;
                        state_d          = ST_IDLE;
                        cnt_d            = '0;
                    end
                end
                ST_DROP: begin
                    rx_pl_ready = 1'b1;
                    if (rx_pl_valid && rx_pl_eop)
                        state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dst_q     <= 1'b0;
            pid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            pid_err_q <= pid_err_d;
        end
    end

    assign rx_ro_valid  = slot_valid & ~out_beat.dst;
    assign rx_lr_valid  = slot_valid &  out_beat.dst;
    assign rx_ro_sop    = out_beat.sop;
    assign rx_ro_eop    = out_beat.eop;
    assign rx_ro_cancle = out_beat.cancle;
    assign rx_ro_data   = out_beat.data;
    assign rx_lr_sop    = out_beat.sop;
    assign rx_lr_eop    = out_beat.eop;
    assign rx_lr_cancle = out_beat.cancle;
    assign rx_lr_data   = out_beat.data;
    assign rx_data_on   = (state_q == ST_DATA);
    assign rx_pid_err   = pid_err_q;

endmodule

// File: tb/tb_control_r.sv
// Bench for control_r: directed packet scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a packet-level model.
module tb_control_r;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pl_sop, rx_pl_eop, rx_pl_valid, rx_pl_ready;
    logic [7:0] rx_pl_data;
    logic       rx_ro_sop, rx_ro_eop, rx_ro_valid, rx_ro_ready, rx_ro_cancle;
    logic [7:0] rx_ro_data;
    logic       rx_lr_sop, rx_lr_eop, rx_lr_valid, rx_lr_ready, rx_lr_cancle;
    logic [7:0] rx_lr_data;
    logic       rx_data_on, rx_pid_err;

    int n_vec = 0;
    int n_bad = 0;
    bit run_chk = 1'b0;

    always #5 clk = ~clk;

    control_r dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pl_sop    (rx_pl_sop),
        .rx_pl_eop    (rx_pl_eop),
        .rx_pl_valid  (rx_pl_valid),
        .rx_pl_ready  (rx_pl_ready),
        .rx_pl_data   (rx_pl_data),
        .rx_ro_sop    (rx_ro_sop),
        .rx_ro_eop    (rx_ro_eop),
        .rx_ro_valid  (rx_ro_valid),
        .rx_ro_ready  (rx_ro_ready),
        .rx_ro_data   (rx_ro_data),
        .rx_ro_cancle (rx_ro_cancle),
        .rx_lr_sop    (rx_lr_sop),
        .rx_lr_eop    (rx_lr_eop),
        .rx_lr_valid  (rx_lr_valid),
        .rx_lr_ready  (rx_lr_ready),
        .rx_lr_data   (rx_lr_data),
        .rx_lr_cancle (rx_lr_cancle),
        .rx_data_on   (rx_data_on),
        .rx_pid_err   (rx_pid_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct packed {
        bit       sop;
        bit       eop;
        bit       cancle;
        bit       dst;
        bit [7:0] data;
    } beat_s;

    typedef enum {M_IDLE, M_PKT, M_ABORT, M_DROP} mode_e;

    beat_s m_slot[$];
    mode_e m_mode = M_IDLE;
    bit    m_dst = 1'b0;
    int    m_len = 0;
    bit    m_pid_err = 1'b0;

    function automatic bit good_pid(input bit [7:0] p);
        return (p[7:4] ^ p[3:0]) == 4'hF;
    endfunction

    function automatic bit data_pid(input bit [7:0] p);
        return p inside {8'hC3, 8'h4B, 8'h87, 8'h0F};
    endfunction

    always @(negedge clk) begin
        if (run_chk) begin
            bit    has, free, rdy, push, perr, over;
            beat_s b, nb;
            has = m_slot.size() != 0;
            b   = '0;
            if (has) b = m_slot[0];
            check("ro_valid", rx_ro_valid, 32'(has && !b.dst));
            check("lr_valid", rx_lr_valid, 32'(has && b.dst));
            if (has && !b.dst) begin
                check("ro_sop",    rx_ro_sop,    32'(b.sop));
                check("ro_eop",    rx_ro_eop,    32'(b.eop));
                check("ro_cancle", rx_ro_cancle, 32'(b.cancle));
                check("ro_data",   rx_ro_data,   32'(b.data));
            end
            if (has && b.dst) begin
                check("lr_sop",    rx_lr_sop,    32'(b.sop));
                check("lr_eop",    rx_lr_eop,    32'(b.eop));
                check("lr_cancle", rx_lr_cancle, 32'(b.cancle));
                check("lr_data",   rx_lr_data,   32'(b.data));
            end
            check("data_on", rx_data_on, 32'(m_mode == M_PKT && m_dst));
            check("pid_err", rx_pid_err, 32'(m_pid_err));

            free = !has || (b.dst ? rx_lr_ready : rx_ro_ready);
            rdy  = 1'b0;
            push = 1'b0;
            perr = 1'b0;
            nb   = '0;
            if (m_mode == M_PKT && rx_pl_valid && rx_pl_sop) begin
                m_mode = M_ABORT;
            end else if (m_mode == M_ABORT) begin
                if (free) begin
                    push      = 1'b1;
                    nb.eop    = 1'b1;
                    nb.cancle = 1'b1;
                    nb.dst    = m_dst;
                    m_mode    = M_IDLE;
                end
            end else if (m_mode == M_PKT) begin
                rdy = free;
                if (rx_pl_valid && free) begin
                    m_len++;
                    over      = m_len > (m_dst ? 1027 : 3);
                    push      = 1'b1;
                    nb.eop    = rx_pl_eop || over;
                    nb.cancle = over;
                    nb.dst    = m_dst;
                    nb.data   = rx_pl_data;
                    if (rx_pl_eop)  m_mode = M_IDLE;
                    else if (over)  m_mode = M_DROP;
                end
            end else if (rx_pl_sop) begin
                if (!good_pid(rx_pl_data)) begin
                    rdy = 1'b1;
                    if (rx_pl_valid) begin
                        perr   = 1'b1;
                        m_mode = rx_pl_eop ? M_IDLE : M_DROP;
                    end
                end else begin
                    rdy = free;
                    if (rx_pl_valid && free) begin
                        push    = 1'b1;
                        nb.sop  = 1'b1;
                        nb.eop  = rx_pl_eop;
                        nb.dst  = data_pid(rx_pl_data);
                        nb.data = rx_pl_data;
                        m_dst   = data_pid(rx_pl_data);
                        m_len   = 1;
                        m_mode  = rx_pl_eop ? M_IDLE : M_PKT;
                    end
                end
            end else begin
                rdy = 1'b1;
                if (m_mode == M_DROP && rx_pl_valid && rx_pl_eop) m_mode = M_IDLE;
            end
            if (rx_pl_valid) check("pl_ready", rx_pl_ready, 32'(rdy));

            if (has && free) void'(m_slot.pop_front());
            if (push) m_slot.push_back(nb);
            m_pid_err = perr;
            if (rst) begin
                m_slot.delete();
                m_mode    = M_IDLE;
                m_pid_err = 1'b0;
                m_len     = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rx_pl_valid = 1'b0;
        rx_pl_sop   = 1'b0;
        rx_pl_eop   = 1'b0;
    endtask

    task automatic drive(input bit s, input bit e, input bit [7:0] d);
        rx_pl_valid = 1'b1;
        rx_pl_sop   = s;
        rx_pl_eop   = e;
        rx_pl_data  = d;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s, input bit e, input bit [7:0] d);
        bit r;
        int n;
        n = 0;
        drive(s, e, d);
        do begin
            @(negedge clk);
            r = rx_pl_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 100);
        if (!r) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: byte %0h not accepted, expected acceptance within 100 cycles", d);
        end
        #1 idle_inputs();
    endtask

    bit [7:0] pids [11] = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hD2, 8'h5A, 8'h1E,
                            8'hC3, 8'h4B, 8'h87, 8'h0F};

    initial begin
        rst = 1'b1;
        idle_inputs();
        rx_pl_data  = 8'h00;
        rx_ro_ready = 1'b1;
        rx_lr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_chk = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_ro_valid", rx_ro_valid, 0);
        check("rst_lr_valid", rx_lr_valid, 0);
        check("rst_ro_data",  rx_ro_data,  0);
        check("rst_lr_eop",   rx_lr_eop,   0);
        check("rst_pid_err",  rx_pid_err,  0);
        check("rst_data_on",  rx_data_on,  0);
        check("rst_pl_ready", rx_pl_ready, 1);
        sync();

        // 1: ACK single-byte token
        send(1, 1, 8'hD2);
        @(negedge clk);
        check("t1_ro_valid", rx_ro_valid, 1);
        check("t1_ro_sop",   rx_ro_sop,   1);
        check("t1_ro_eop",   rx_ro_eop,   1);
        check("t1_ro_data",  rx_ro_data,  8'hD2);
        check("t1_data_on",  rx_data_on,  0);
        sync();

        // 2: DATA0 packet on the data path
        send(1, 0, 8'hC3);
        @(negedge clk);
        check("t2_lr_sop",   rx_lr_sop,  1);
        check("t2_data_on",  rx_data_on, 1);
        sync();
        send(0, 0, 8'h01);
        send(0, 0, 8'h02);
        send(0, 0, 8'hAA);
        send(0, 1, 8'hBB);
        @(negedge clk);
        check("t2_lr_data",  rx_lr_data, 8'hBB);
        check("t2_lr_eop",   rx_lr_eop,  1);
        check("t2_data_off", rx_data_on, 0);
        sync();

        // 3: bad PID dropped
        send(1, 0, 8'hC4);
        @(negedge clk);
        check("t3_pid_err",  rx_pid_err,  1);
        check("t3_ro_valid", rx_ro_valid, 0);
        sync();
        send(0, 0, 8'h11);
        @(negedge clk);
        check("t3_pid_once", rx_pid_err,  0);
        sync();
        send(0, 1, 8'h22);
        @(negedge clk);
        check("t3_lr_valid", rx_lr_valid, 0);
        sync();

        // 4: back-pressure on the data path
        send(1, 0, 8'h4B);
        send(0, 0, 8'h10);
        rx_lr_ready = 1'b0;
        drive(0, 0, 8'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_pl_ready", rx_pl_ready, 0);
            check("t4_lr_hold",  rx_lr_data,  8'h10);
        end
        sync();
        rx_lr_ready = 1'b1;
        send(0, 0, 8'h20);
        send(0, 1, 8'h30);
        @(negedge clk);
        check("t4_lr_last", rx_lr_data, 8'h30);
        sync();

        // 5: over-length token, then an in-limit token
        send(1, 0, 8'hE1);
        send(0, 0, 8'h05);
        send(0, 0, 8'h3A);
        send(0, 1, 8'h77);
        @(negedge clk);
        check("t5_ro_data",   rx_ro_data,   8'h77);
        check("t5_ro_eop",    rx_ro_eop,    1);
        check("t5_ro_cancle", rx_ro_cancle, 1);
        sync();
        send(1, 0, 8'h69);
        send(0, 0, 8'h01);
        send(0, 1, 8'h02);
        @(negedge clk);
        check("t5_ok_cancle", rx_ro_cancle, 0);
        check("t5_ok_eop",    rx_ro_eop,    1);
        sync();

        // 6: sop interrupts a data packet
        send(1, 0, 8'hC3);
        send(0, 0, 8'h01);
        drive(1, 1, 8'hD2);
        @(negedge clk);
        check("t6_stall", rx_pl_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check("t6_lr_valid",  rx_lr_valid,  1);
        check("t6_lr_cancle", rx_lr_cancle, 1);
        check("t6_lr_eop",    rx_lr_eop,    1);
        check("t6_lr_data",   rx_lr_data,   8'h00);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check("t6_ro_valid", rx_ro_valid, 1);
        check("t6_ro_data",  rx_ro_data,  8'hD2);
        sync();

        // 7: reset mid-packet
        send(1, 0, 8'hC3);
        send(0, 0, 8'h01);
        send(0, 0, 8'h02);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("t7_lr_valid", rx_lr_valid, 0);
        check("t7_data_on",  rx_data_on,  0);
        sync();
        send(1, 0, 8'h87);
        @(negedge clk);
        check("t7_lr_sop",  rx_lr_sop,  1);
        check("t7_lr_data", rx_lr_data, 8'h87);
        sync();
        send(0, 1, 8'h99);

        // data-path length limit: exactly 1027 bytes, then 1028
        send(1, 0, 8'hC3);
        for (int i = 0; i < 1025; i++) send(0, 0, 8'(i));
        send(0, 1, 8'h5E);
        @(negedge clk);
        check("len_max_eop",    rx_lr_eop,    1);
        check("len_max_cancle", rx_lr_cancle, 0);
        sync();
        send(1, 0, 8'h0F);
        for (int i = 0; i < 1026; i++) send(0, 0, 8'(i + 7));
        send(0, 0, 8'hA7);
        @(negedge clk);
        check("len_over_data",   rx_lr_data,   8'hA7);
        check("len_over_cancle", rx_lr_cancle, 1);
        sync();
        send(0, 0, 8'h11);
        send(0, 1, 8'h22);
        @(negedge clk);
        check("len_drop_valid", rx_lr_valid, 0);
        sync();

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            rx_pl_valid = ($urandom_range(0, 9) < 7);
            rx_pl_sop   = ($urandom_range(0, 7) == 0);
            rx_pl_eop   = ($urandom_range(0, 5) == 0);
            if (rx_pl_sop && $urandom_range(0, 3) != 0)
                rx_pl_data = pids[$urandom_range(0, 10)];
            else
                rx_pl_data = 8'($urandom);
            rx_ro_ready = ($urandom_range(0, 3) != 0);
            rx_lr_ready = ($urandom_range(0, 3) != 0);
            sync();
        end
        rst = 1'b0;
        idle_inputs();
        rx_ro_ready = 1'b1;
        rx_lr_ready = 1'b1;
        repeat (4) sync();
        run_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
